// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: default geometry and the fill/full state type.
package byte_packer_pkg;

  localparam int BP_DATA_WIDTH = 8;
  localparam int BP_RATIO      = 4;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } bp_state_e;

  function automatic int bp_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs RATIO narrow beats into one wide word with per-lane keep bits.
// The output register doubles as the single-entry buffer, so a full word blocks input.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int DATA_WIDTH = BP_DATA_WIDTH,
  parameter int RATIO      = BP_RATIO,
  parameter int OUT_WIDTH  = DATA_WIDTH * RATIO,
  parameter int CNT_WIDTH  = bp_clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  idata_vld,
  input  logic                  idata_last,
  output logic                  idata_rdy,
  output logic [OUT_WIDTH-1:0]  odata,
  output logic [RATIO-1:0]      odata_keep,
  output logic                  odata_last,
  output logic                  odata_vld,
  input  logic                  odata_rdy
);

  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(RATIO - 1);

  bp_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]     keep_q, keep_d;
  logic                 last_q, last_d;
  logic                 accept;
  logic                 complete;

  assign idata_rdy  = (state_q == ST_FILL) | odata_rdy;
  assign accept     = idata_vld & idata_rdy;
  assign complete   = (cnt_q == LAST_LANE) | idata_last;

  assign odata      = data_q;
  assign odata_keep = keep_q;
  assign odata_last = last_q;
  assign odata_vld  = (state_q == ST_FULL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;

    // Handoff empties the buffer; an accepted beat below may refill it in the same edge.
    if ((state_q == ST_FULL) && odata_rdy) begin
      state_d = ST_FILL;
      keep_d  = '0;
      last_d  = 1'b0;
    end

    if (accept) begin
      if (cnt_q == '0) begin
        data_d                 = '0;
        data_d[DATA_WIDTH-1:0] = idata;
        keep_d                 = RATIO'(1);
      end else begin
        for (int i = 1; i < RATIO; i++) begin
          if (cnt_q == CNT_WIDTH'(i)) begin
            data_d[i*DATA_WIDTH +: DATA_WIDTH] = idata;
            keep_d[i]                          = 1'b1;
          end
        end
      end

      if (complete) begin
        state_d = ST_FULL;
        last_d  = idata_last;
        cnt_d   = '0;
      end else begin
        state_d = ST_FILL;
        last_d  = 1'b0;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

endmodule
